tdm_demux8: RTL and testbench



---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_ctr.sv | 39 +++
 rtl/tdm_demux8.sv | 137 +++++++++++++
 tb/tb_tdm_demux8.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer and its companion serializer.
package tdm_pkg;

   localparam int N_LANES_DEF = 8;
   localparam int SEL_W_DEF   = $clog2(N_LANES_DEF);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: wraps modulo 2**SEL_W, loads 1 on a frame start, reports the
// wrap combinationally so the owner can act on the edge that completes a frame.
module tdm_slot_ctr #(
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_load1,
   input  logic             i_clear,
   output logic [SEL_W-1:0] o_cnt,
   output logic             o_wrap
);

   localparam logic [SEL_W-1:0] C_ZERO = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0] C_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] C_MAX  = {SEL_W{1'b1}};

   logic [SEL_W-1:0] r_cnt;

   assign o_cnt  = r_cnt;
   assign o_wrap = i_inc & (r_cnt == C_MAX);

   // Counter register: clear beats load-to-1, which beats increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= C_ZERO;
      end else if (i_clear) begin
         r_cnt <= C_ZERO;
      end else if (i_load1) begin
         r_cnt <= C_ONE;
      end else if (i_inc) begin
         r_cnt <= r_cnt + C_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/tdm_demux8.sv
// Receive side of an 8:1 TDM serial link: steers each accepted bit into a
// shadow lane and publishes a completed frame as one byte with a valid pulse.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int N_LANES = N_LANES_DEF,
   parameter int SEL_W   = $clog2(N_LANES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               sof,
   output logic [N_LANES-1:0] dout,
   output logic               dout_valid,
   output logic [SEL_W-1:0]   slot,
   output logic               frame_err
);

   localparam logic [SEL_W-1:0] C_SLOT0 = {SEL_W{1'b0}};

   tdm_state_t         r_state;
   tdm_state_t         w_next_state;
   logic [N_LANES-2:0] r_shadow;
   logic [N_LANES-1:0] r_dout;
   logic               r_dout_valid;
   logic               r_frame_err;

   logic               w_store;
   logic               w_load1;
   logic               w_inc;
   logic               w_err;
   logic               w_done;
   logic [SEL_W-1:0]   w_slot;
   logic [SEL_W-1:0]   w_idx;

   tdm_slot_ctr #(
      .SEL_W (SEL_W)
   ) u_slot_ctr (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_inc),
      .i_load1 (w_load1),
      .i_clear (1'b0),
      .o_cnt   (w_slot),
      .o_wrap  (w_done)
   );

   // A frame start always lands in slot 0; otherwise the bit goes where the counter points.
   assign w_idx = w_load1 ? C_SLOT0 : w_slot;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-bit control decode.
   always_comb begin
      w_next_state = r_state;
      w_store      = 1'b0;
      w_load1      = 1'b0;
      w_inc        = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         IDLE: begin
            if (din_valid && sof) begin
               w_store      = 1'b1;
               w_load1      = 1'b1;
               w_next_state = RUN;
            end else begin
               w_next_state = IDLE;
            end
         end
         RUN: begin
            if (din_valid) begin
               if (sof && (w_slot != C_SLOT0)) begin
                  // Early start: abandon the partial frame and restart at slot 0.
                  w_err   = 1'b1;
                  w_store = 1'b1;
                  w_load1 = 1'b1;
               end else begin
                  // Includes sof at slot 0, which is just an ordinary slot-0 bit.
                  w_store = 1'b1;
                  w_inc   = 1'b1;
               end
            end else begin
               w_next_state = RUN;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Shadow lanes 0..N-2; the final slot bypasses the shadow straight into dout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow <= {(N_LANES-1){1'b0}};
      end else begin
         for (int i = 0; i < N_LANES - 1; i++) begin
            if (w_store && (w_idx == SEL_W'(i))) begin
               r_shadow[i] <= din;
            end else begin
               r_shadow[i] <= r_shadow[i];
            end
         end
      end
   end

   // Output byte and one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout       <= {N_LANES{1'b0}};
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_dout_valid <= w_done;
         r_frame_err  <= w_err;
         if (w_done) begin
            r_dout <= {din, r_shadow};
         end else begin
            r_dout <= r_dout;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_err  = r_frame_err;
   assign slot       = w_slot;

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: directed scenarios plus random traffic,
// all compared against a queue-based frame model.
module tb_tdm_demux8;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         din;
   logic         din_valid;
   logic         sof;
   logic [N-1:0] dout;
   logic         dout_valid;
   logic [2:0]   slot;
   logic         frame_err;

   int n_chk;
   int n_err;

   // Reference model: bits of the frame in progress, last published byte, pulses.
   bit           m_run;
   bit           m_frame[$];
   logic [N-1:0] m_dout;
   logic         m_valid;
   logic         m_err;

   tdm_demux8 dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .sof        (sof),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_run = 1'b0;
      m_frame.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic s, input logic d);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (v) begin
         if (s) begin
            if (m_run && m_frame.size() != 0) m_err = 1'b1;
            m_frame.delete();
            m_frame.push_back(d);
            m_run = 1'b1;
         end else if (m_run) begin
            m_frame.push_back(d);
            if (m_frame.size() == N) begin
               for (int i = 0; i < N; i++) m_dout[i] = m_frame[i];
               m_valid = 1'b1;
               m_frame.delete();
            end
         end
      end
   endtask

   function automatic logic [2:0] m_slot();
      return 3'(m_frame.size());
   endfunction

   // Apply one cycle of input, advance the model on the edge, settle 1 ns past it.
   task automatic drive(input logic v, input logic s, input logic d);
      din_valid = v;
      sof       = s;
      din       = d;
      @(posedge clk);
      model_step(v, s, d);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din_valid = 1'b0; sof = 1'b0; din = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({dout_valid, frame_err, slot, dout} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
         n_err++;
         $display("FAIL reset: got valid=%b err=%b slot=%0d dout=%h, want 0/0/0/00",
                  dout_valid, frame_err, slot, dout);
      end
   endtask

   task automatic test_single_frame();
      logic [N-1:0] b;
      b = 8'h09;
      do_reset();
      for (int i = 0; i < N; i++) begin
         drive(1'b1, (i == 0), b[i]);
         n_chk++;
         if ({dout_valid, frame_err, slot, dout} !== {m_valid, m_err, m_slot(), m_dout}) begin
            n_err++;
            $display("FAIL single_frame[%0d]: got %b/%b/%0d/%h want %b/%b/%0d/%h", i,
                     dout_valid, frame_err, slot, dout, m_valid, m_err, m_slot(), m_dout);
         end
      end
      n_chk++;
      if (dout !== 8'h09 || dout_valid !== 1'b1) begin
         n_err++;
         $display("FAIL single_frame_out: got dout=%h valid=%b want 09/1", dout, dout_valid);
      end
      drive(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (dout_valid !== 1'b0 || slot !== 3'd0 || dout !== 8'h09) begin
         n_err++;
         $display("FAIL single_frame_after: got valid=%b slot=%0d dout=%h want 0/0/09",
                  dout_valid, slot, dout);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*N-1:0] b;
      int pulses, first_cyc, second_cyc, errs;
      b = {8'h3C, 8'hA5};
      pulses = 0; errs = 0; first_cyc = -1; second_cyc = -1;
      do_reset();
      for (int i = 0; i < 2 * N; i++) begin
         drive(1'b1, (i == 0), b[i]);
         if (frame_err) errs++;
         if (dout_valid) begin
            pulses++;
            if (pulses == 1) begin
               first_cyc = i;
               n_chk++;
               if (dout !== 8'hA5) begin
                  n_err++;
                  $display("FAIL b2b_first: got dout=%h want a5", dout);
               end
            end else begin
               second_cyc = i;
               n_chk++;
               if (dout !== 8'h3C) begin
                  n_err++;
                  $display("FAIL b2b_second: got dout=%h want 3c", dout);
               end
            end
         end
      end
      n_chk++;
      if (pulses != 2 || (second_cyc - first_cyc) != 8 || errs != 0) begin
         n_err++;
         $display("FAIL b2b_timing: got pulses=%0d spacing=%0d errs=%0d want 2/8/0",
                  pulses, second_cyc - first_cyc, errs);
      end
   endtask

   task automatic test_gapped();
      logic [N-1:0] b;
      b = 8'hF0;
      do_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), b[i]);
      for (int g = 0; g < 3; g++) begin
         drive(1'b0, (g == 1), 1'b1);
         n_chk++;
         if (slot !== 3'd4 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL gap_hold[%0d]: got slot=%0d valid=%b err=%b want 4/0/0",
                     g, slot, dout_valid, frame_err);
         end
      end
      for (int i = 4; i < N; i++) drive(1'b1, 1'b0, b[i]);
      n_chk++;
      if (dout !== 8'hF0 || dout_valid !== 1'b1 || slot !== 3'd0) begin
         n_err++;
         $display("FAIL gap_out: got dout=%h valid=%b slot=%0d want f0/1/0",
                  dout, dout_valid, slot);
      end
   endtask

   task automatic test_early_sof();
      logic [N-1:0] b;
      int errs, pulses;
      b = 8'h81; errs = 0; pulses = 0;
      do_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'b1);
      for (int i = 0; i < N; i++) begin
         drive(1'b1, (i == 0), b[i]);
         if (frame_err) errs++;
         if (dout_valid) pulses++;
         if (i == 0) begin
            n_chk++;
            if (frame_err !== 1'b1 || slot !== 3'd1) begin
               n_err++;
               $display("FAIL early_sof_abort: got err=%b slot=%0d want 1/1", frame_err, slot);
            end
         end
      end
      n_chk++;
      if (dout !== 8'h81 || errs != 1 || pulses != 1) begin
         n_err++;
         $display("FAIL early_sof_out: got dout=%h errs=%0d pulses=%0d want 81/1/1",
                  dout, errs, pulses);
      end
   endtask

   task automatic test_idle_discard();
      logic [N-1:0] b;
      int errs;
      b = 8'h55; errs = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         n_chk++;
         if (slot !== 3'd0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_discard[%0d]: got slot=%0d valid=%b want 0/0", i, slot, dout_valid);
         end
      end
      for (int i = 0; i < N; i++) begin
         drive(1'b1, (i == 0), b[i]);
         if (frame_err) errs++;
      end
      n_chk++;
      if (dout !== 8'h55 || dout_valid !== 1'b1 || errs != 0) begin
         n_err++;
         $display("FAIL idle_frame: got dout=%h valid=%b errs=%0d want 55/1/0", dout, dout_valid, errs);
      end
   endtask

   task automatic test_async_reset();
      logic [N-1:0] b;
      b = 8'hC3;
      do_reset();
      for (int i = 0; i < N; i++) drive(1'b1, (i == 0), b[i]);
      for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), 1'b1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_chk++;
      if (dout !== 8'h00 || slot !== 3'd0 || dout_valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got dout=%h slot=%0d valid=%b want 00/0/0", dout, slot, dout_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b1);
      n_chk++;
      if (slot !== 3'd0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
         n_err++;
         $display("FAIL after_reset_ignore: got slot=%0d valid=%b dout=%h want 0/0/00",
                  slot, dout_valid, dout);
      end
   endtask

   task automatic test_random();
      logic v, s, d;
      int bad;
      bad = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         v = ($urandom % 4) != 0;
         s = ($urandom % 12) == 0;
         d = $urandom % 2;
         drive(v, s, d);
         n_chk++;
         if ({dout_valid, frame_err, slot, dout} !== {m_valid, m_err, m_slot(), m_dout}) begin
            n_err++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d]: got %b/%b/%0d/%h want %b/%b/%0d/%h", c,
                        dout_valid, frame_err, slot, dout, m_valid, m_err, m_slot(), m_dout);
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      din = 1'b0; din_valid = 1'b0; sof = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gapped();
      test_early_sof();
      test_idle_discard();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
